// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the single SRAM port between the pixel read
// engine and the result write engine.
//   - Grants whole bursts of BURST_LEN beats with round-robin fairness on ties.
//   - Drives per-beat strobes and addresses (base + beat_cnt * ADDR_STEP).
//   - Inserts one RELEASE cycle after every burst; rd_done/wr_done pulse there.
// Optional feature macro: ARB_TIMEOUT_EN. When defined, a burst that sees no
// mem_ack for TIMEOUT_CYC cycles is aborted (abort pulse, no done pulse).
// Without the macro, abort is tied low and bursts wait for mem_ack forever.
// n_rst is an asynchronous, active-HIGH reset despite its legacy name.
module mem_access_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 8,
  parameter int ADDR_STEP   = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_beat,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_beat,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              abort
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_READ  = 1'b0,
    OWN_WRITE = 1'b1
  } owner_e;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;

  logic              in_burst;
  logic              timeout_hit;
  logic [ADDR_W-1:0] beat_off;

  // Read data goes straight from the SRAM to the read engine; the arbiter
  // only qualifies it with rd_beat.
  logic              rdata_unused;
  assign rdata_unused = ^mem_rdata;

  assign in_burst = (state_q == RD_BURST) || (state_q == WR_BURST);

`ifdef ARB_TIMEOUT_EN
  localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Stall counter: counts un-acked burst cycles, zero on any ack and outside bursts.
  always_comb begin
    wait_d = '0;
    if (in_burst && !mem_ack) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  // The TIMEOUT_CYC-th consecutive cycle without an ack aborts the burst.
  assign timeout_hit = in_burst && !mem_ack && (wait_q == WAIT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign abort = timeout_hit;

  // Arbitration, burst sequencing and done-pulse scheduling.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    base_d       = base_q;
    beat_cnt_d   = beat_cnt_q;
    rd_done_d    = 1'b0;
    wr_done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the requester that did not own the port last time wins.
        if (rd_req && (!wr_req || (last_owner_q == OWN_WRITE))) begin
          state_d      = RD_BURST;
          base_d       = rd_addr;
          beat_cnt_d   = '0;
          last_owner_d = OWN_READ;
        end else if (wr_req) begin
          state_d      = WR_BURST;
          base_d       = wr_addr;
          beat_cnt_d   = '0;
          last_owner_d = OWN_WRITE;
        end
      end

      RD_BURST: begin
        if (mem_ack) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // A dropped request only ends the burst once the in-flight beat is acked.
          if ((beat_cnt_q == LAST_BEAT) || !rd_req) begin
            state_d   = RELEASE;
            rd_done_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = RELEASE;
        end
      end

      WR_BURST: begin
        if (mem_ack) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if ((beat_cnt_q == LAST_BEAT) || !wr_req) begin
            state_d   = RELEASE;
            wr_done_d = 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        // Dead cycle: the port is idle for one cycle before re-arbitration.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and burst-context registers; reset leaves read as winner of the first tie.
  always_ff @(posedge clk or posedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same pre-edge snapshot.
    if (n_rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_WRITE;
      base_q       <= '0;
      beat_cnt_q   <= '0;
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      base_q       <= base_d;
      beat_cnt_q   <= beat_cnt_d;
      rd_done_q    <= rd_done_d;
      wr_done_q    <= wr_done_d;
    end
  end

  // Beat address offset; the sum wraps silently at the top of the address space.
  assign beat_off = ADDR_W'(beat_cnt_q) * ADDR_W'(ADDR_STEP);

  assign rd_gnt    = (state_q == RD_BURST);
  assign wr_gnt    = (state_q == WR_BURST);
  assign mem_ren   = rd_gnt;
  assign mem_wen   = wr_gnt;
  assign rd_beat   = rd_gnt && mem_ack;
  assign wr_beat   = wr_gnt && mem_ack;
  assign mem_addr  = in_burst ? (base_q + beat_off) : '0;
  assign mem_wdata = wr_gnt ? wr_data : '0;
  assign rd_done   = rd_done_q;
  assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed testbench for mem_access_arbiter. Inputs change 1 ns after the
// rising edge and outputs are sampled 1 ns later, well clear of the edge.
// Control outputs are packed into one vector:
//   {rd_gnt, wr_gnt, mem_ren, mem_wen, rd_beat, wr_beat, rd_done, wr_done, abort}
module tb_mem_access_arbiter;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int BURST_LEN   = 8;
  localparam int ADDR_STEP   = 1;
  localparam int TIMEOUT_CYC = 64;

  localparam logic [8:0] CTL_IDLE     = 9'b000000000;
  localparam logic [8:0] CTL_RD_ACK   = 9'b101010000;
  localparam logic [8:0] CTL_RD_WAIT  = 9'b101000000;
  localparam logic [8:0] CTL_WR_ACK   = 9'b010101000;
  localparam logic [8:0] CTL_WR_WAIT  = 9'b010100000;
  localparam logic [8:0] CTL_RD_DONE  = 9'b000000100;
  localparam logic [8:0] CTL_WR_DONE  = 9'b000000010;
  localparam logic [8:0] CTL_WR_ABORT = 9'b010100001;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_gnt, rd_beat, rd_done;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_beat, wr_gnt, wr_done;
  logic              mem_ren, mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = 8'h5A;
  logic              abort;

  logic [8:0]        ctl;
  int                checks = 0;
  int                errors = 0;

  assign ctl = {rd_gnt, wr_gnt, mem_ren, mem_wen, rd_beat, wr_beat, rd_done, wr_done, abort};

  mem_access_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .BURST_LEN  (BURST_LEN),
    .ADDR_STEP  (ADDR_STEP),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_beat  (rd_beat),
    .rd_done  (rd_done),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_beat  (wr_beat),
    .wr_gnt   (wr_gnt),
    .wr_done  (wr_done),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .abort    (abort)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst   = 1'b1;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b0;
  endtask

  task automatic test_reset();
    n_rst   = 1'b1;
    wr_data = 8'hFF;
    rd_addr = 16'hFFFF;
    wr_addr = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL reset ctl: got %b expected %b", ctl, CTL_IDLE); end
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset mem_addr: got %h expected 0000", mem_addr); end
    checks++;
    if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset mem_wdata: got %h expected 00", mem_wdata); end
    n_rst = 1'b0;
    tick();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL post-reset idle ctl: got %b expected %b", ctl, CTL_IDLE); end
  endtask

  task automatic test_read_burst();
    logic [ADDR_W-1:0] exp_addr;
    do_reset();
    rd_addr = 16'h0100;
    rd_req  = 1'b1;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL rd grant latency ctl: got %b expected %b", ctl, CTL_IDLE); end
    for (int i = 0; i < BURST_LEN; i++) begin
      tick();
      if (i == BURST_LEN - 1) rd_req = 1'b0;
      #1;
      exp_addr = 16'h0100 + 16'(i);
      checks++;
      if (ctl !== CTL_RD_ACK) begin errors++; $display("FAIL rd burst ctl beat %0d: got %b expected %b", i, ctl, CTL_RD_ACK); end
      checks++;
      if (mem_addr !== exp_addr) begin errors++; $display("FAIL rd burst addr beat %0d: got %h expected %h", i, mem_addr, exp_addr); end
    end
    tick();
    checks++;
    if (ctl !== CTL_RD_DONE) begin errors++; $display("FAIL rd release ctl: got %b expected %b", ctl, CTL_RD_DONE); end
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rd release addr: got %h expected 0000", mem_addr); end
    tick();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL rd after-done ctl: got %b expected %b", ctl, CTL_IDLE); end
    mem_ack = 1'b0;
  endtask

  task automatic test_round_robin();
    int                p;
    logic [8:0]        exp_ctl;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    do_reset();
    rd_addr = 16'h0400;
    wr_addr = 16'h0800;
    wr_data = 8'hA5;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    mem_ack = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 39) begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      #1;
      p = c % 20;
      exp_addr  = 16'h0000;
      exp_wdata = 8'h00;
      if (p < 8) begin
        exp_ctl  = CTL_RD_ACK;
        exp_addr = 16'h0400 + 16'(p);
      end else if (p == 8) begin
        exp_ctl = CTL_RD_DONE;
      end else if (p == 9) begin
        exp_ctl = CTL_IDLE;
      end else if (p < 18) begin
        exp_ctl   = CTL_WR_ACK;
        exp_addr  = 16'h0800 + 16'(p - 10);
        exp_wdata = 8'hA5;
      end else if (p == 18) begin
        exp_ctl = CTL_WR_DONE;
      end else begin
        exp_ctl = CTL_IDLE;
      end
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL rr ctl cycle %0d: got %b expected %b", c, ctl, exp_ctl); end
      checks++;
      if (mem_addr !== exp_addr) begin errors++; $display("FAIL rr addr cycle %0d: got %h expected %h", c, mem_addr, exp_addr); end
      checks++;
      if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL rr wdata cycle %0d: got %h expected %h", c, mem_wdata, exp_wdata); end
    end
    tick();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL rr final idle ctl: got %b expected %b", ctl, CTL_IDLE); end
    mem_ack = 1'b0;
  endtask

  task automatic test_write_stall();
    logic [8:0]        exp_ctl;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    do_reset();
    wr_addr = 16'h2000;
    wr_data = 8'h30;
    wr_req  = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      mem_ack = ((k % 3) == 2);
      wr_data = 8'h30 + 8'(k / 3);
      if (k == 23) wr_req = 1'b0;
      #1;
      exp_ctl   = mem_ack ? CTL_WR_ACK : CTL_WR_WAIT;
      exp_addr  = 16'h2000 + 16'(k / 3);
      exp_wdata = 8'h30 + 8'(k / 3);
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL wr stall ctl cycle %0d: got %b expected %b", k, ctl, exp_ctl); end
      checks++;
      if (mem_addr !== exp_addr) begin errors++; $display("FAIL wr stall addr cycle %0d: got %h expected %h", k, mem_addr, exp_addr); end
      checks++;
      if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL wr stall wdata cycle %0d: got %h expected %h", k, mem_wdata, exp_wdata); end
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_WR_DONE) begin errors++; $display("FAIL wr stall done ctl: got %b expected %b", ctl, CTL_WR_DONE); end
    tick();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL wr stall idle ctl: got %b expected %b", ctl, CTL_IDLE); end
  endtask

  task automatic test_early_term();
    logic [ADDR_W-1:0] exp_addr;
    do_reset();
    rd_addr = 16'h0040;
    rd_req  = 1'b1;
    mem_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) rd_req = 1'b0;
      #1;
      exp_addr = 16'h0040 + 16'(k);
      checks++;
      if (ctl !== CTL_RD_ACK) begin errors++; $display("FAIL early ctl beat %0d: got %b expected %b", k, ctl, CTL_RD_ACK); end
      checks++;
      if (mem_addr !== exp_addr) begin errors++; $display("FAIL early addr beat %0d: got %h expected %h", k, mem_addr, exp_addr); end
    end
    tick();
    checks++;
    if (ctl !== CTL_RD_DONE) begin errors++; $display("FAIL early done ctl: got %b expected %b", ctl, CTL_RD_DONE); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ctl !== CTL_IDLE) begin errors++; $display("FAIL early idle ctl cycle %0d: got %b expected %b", k, ctl, CTL_IDLE); end
    end
    // Request dropped while a beat is stalled: that beat still completes.
    rd_addr = 16'h0050;
    rd_req  = 1'b1;
    tick();
    checks++;
    if (ctl !== CTL_RD_ACK || mem_addr !== 16'h0050) begin
      errors++; $display("FAIL stall-drop beat0: got %b/%h expected %b/0050", ctl, mem_addr, CTL_RD_ACK);
    end
    tick();
    rd_req  = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RD_WAIT || mem_addr !== 16'h0051) begin
      errors++; $display("FAIL stall-drop wait: got %b/%h expected %b/0051", ctl, mem_addr, CTL_RD_WAIT);
    end
    tick();
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_RD_ACK || mem_addr !== 16'h0051) begin
      errors++; $display("FAIL stall-drop final beat: got %b/%h expected %b/0051", ctl, mem_addr, CTL_RD_ACK);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RD_DONE) begin errors++; $display("FAIL stall-drop done ctl: got %b expected %b", ctl, CTL_RD_DONE); end
  endtask

  task automatic test_reset_mid_burst();
    logic [ADDR_W-1:0] exp_addr;
    do_reset();
    wr_addr = 16'h3000;
    wr_data = 8'h77;
    wr_req  = 1'b1;
    mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_addr = 16'h3000 + 16'(k);
      checks++;
      if (ctl !== CTL_WR_ACK || mem_addr !== exp_addr) begin
        errors++; $display("FAIL mid-reset pre beat %0d: got %b/%h expected %b/%h", k, ctl, mem_addr, CTL_WR_ACK, exp_addr);
      end
    end
    n_rst  = 1'b1;
    rd_req = 1'b1;
    rd_addr = 16'h0500;
    #1;
    checks++;
    if (ctl !== CTL_IDLE || mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
      errors++; $display("FAIL mid-reset async drop: got %b/%h/%h expected %b/0000/00", ctl, mem_addr, mem_wdata, CTL_IDLE);
    end
    tick();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL mid-reset held ctl: got %b expected %b", ctl, CTL_IDLE); end
    n_rst = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL mid-reset release ctl: got %b expected %b", ctl, CTL_IDLE); end
    tick();
    checks++;
    if (ctl !== CTL_RD_ACK || mem_addr !== 16'h0500) begin
      errors++; $display("FAIL mid-reset tie to read: got %b/%h expected %b/0500", ctl, mem_addr, CTL_RD_ACK);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RD_DONE) begin errors++; $display("FAIL mid-reset follow-up done ctl: got %b expected %b", ctl, CTL_RD_DONE); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [8:0] exp_ctl;
    do_reset();
    wr_addr = 16'h4000;
    wr_req  = 1'b1;
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      tick();
      if (k == TIMEOUT_CYC - 1) wr_req = 1'b0;
      #1;
      exp_ctl = (k == TIMEOUT_CYC - 1) ? CTL_WR_ABORT : CTL_WR_WAIT;
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL timeout ctl cycle %0d: got %b expected %b", k, ctl, exp_ctl); end
    end
    tick();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL timeout release ctl (no done/abort): got %b expected %b", ctl, CTL_IDLE); end
    tick();
    checks++;
    if (ctl !== CTL_IDLE) begin errors++; $display("FAIL timeout idle ctl: got %b expected %b", ctl, CTL_IDLE); end
    rd_addr = 16'h0600;
    rd_req  = 1'b1;
    mem_ack = 1'b1;
    tick();
    checks++;
    if (ctl !== CTL_RD_ACK || mem_addr !== 16'h0600) begin
      errors++; $display("FAIL timeout next burst: got %b/%h expected %b/0600", ctl, mem_addr, CTL_RD_ACK);
    end
    rd_req = 1'b0;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_RD_DONE) begin errors++; $display("FAIL timeout next done ctl: got %b expected %b", ctl, CTL_RD_DONE); end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    wr_addr = 16'h4000;
    wr_req  = 1'b1;
    for (int k = 0; k < TIMEOUT_CYC + 6; k++) begin
      tick();
      checks++;
      if (ctl !== CTL_WR_WAIT || mem_addr !== 16'h4000) begin
        errors++; $display("FAIL long stall cycle %0d: got %b/%h expected %b/4000", k, ctl, mem_addr, CTL_WR_WAIT);
      end
    end
    wr_req  = 1'b0;
    mem_ack = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_WR_ACK) begin errors++; $display("FAIL long stall late ack ctl: got %b expected %b", ctl, CTL_WR_ACK); end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_WR_DONE) begin errors++; $display("FAIL long stall done ctl: got %b expected %b", ctl, CTL_WR_DONE); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_round_robin();
    test_write_stall();
    test_early_term();
    test_reset_mid_burst();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
Shares the single external SRAM port between the pixel read engine (loads the input window into the line buffer) and the result write engine (stores edge-magnitude output).
- Grants whole bursts with round-robin fairness.
- Generates per-beat memory strobes and addresses.
- Reports completion to the main controller via rd_done/wr_done.
- Sits between the read/write transfer engines and the SRAM interface.

Parameters:
ADDR_W, 16, memory address width in bits
DATA_W, 8, pixel data width in bits
BURST_LEN, 8, beats per granted burst (2..255)
ADDR_STEP, 1, address increment per accepted beat
TIMEOUT_CYC, 64, cycles without mem_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  reset; asynchronous, active-high (1 = reset), despite the legacy name
rd_req  input  1  read engine requests a burst; held until rd_gnt
rd_addr  input  ADDR_W  read burst base address; sampled at grant
rd_gnt  output  1  read engine owns the SRAM port
rd_beat  output  1  one read beat accepted this cycle; mem_rdata valid
rd_done  output  1  one-cycle pulse after the last read beat
wr_req  input  1  write engine requests a burst; held until wr_gnt
wr_addr  input  ADDR_W  write burst base address; sampled at grant
wr_data  input  DATA_W  current write beat data
wr_beat  output  1  one write beat accepted; engine advances its data
wr_gnt  output  1  write engine owns the SRAM port
wr_done  output  1  one-cycle pulse after the last write beat
mem_ren  output  1  SRAM read strobe
mem_wen  output  1  SRAM write strobe
mem_addr  output  ADDR_W  SRAM address
mem_wdata  output  DATA_W  SRAM write data (wr_data passed through while write-granted)
mem_ack  input  1  SRAM accepted the current beat
mem_rdata  input  DATA_W  SRAM read data, valid with mem_ack
abort  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: all outputs 0. State IDLE, beat_cnt 0, last_owner = WRITE, so read wins the first tie.
- States: IDLE, RD_BURST, WR_BURST, RELEASE.
- IDLE arbitration:
  - Only rd_req: next state RD_BURST.
  - Only wr_req: next state WR_BURST.
  - Both: the requester that is not last_owner wins.
  - Grant is registered, so gnt asserts one cycle after req is seen.
  - On entry to a burst: latch base address, clear beat_cnt, update last_owner.
- In RD_BURST / WR_BURST:
  - gnt=1 and strobe=1 (mem_ren or mem_wen).
  - mem_addr = base + beat_cnt*ADDR_STEP, truncated to ADDR_W. Wrap-around at the top of the address space is permitted and not flagged.
  - Each cycle with mem_ack=1: beat_cnt increments and rd_beat/wr_beat pulse combinationally with mem_ack.
  - No ack: strobe, address and data hold stable.
- Burst end:
  - Ack on beat BURST_LEN-1, or requester deasserts req (early termination, checked only on acked cycles): go to RELEASE.
  - rd_done/wr_done pulses in the RELEASE cycle.
- RELEASE: one dead cycle. All strobes and grants are 0. Then return to IDLE, giving the other requester guaranteed turnaround.
- Early termination: req dropping while no ack is pending ends the burst at the next ack. The in-flight beat always completes.
- Simultaneous new request during RELEASE: it is evaluated in IDLE the following cycle. Worst-case grant latency for a waiting requester is BURST_LEN + 3 cycles when the SRAM acks every cycle.
- Exactly one of rd_gnt/wr_gnt may be high; never both. mem_ren and mem_wen are never both high.
- Reset mid-burst: outputs drop asynchronously to 0. The burst is not resumed and no done pulse is issued.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A wait counter clears on every mem_ack and on burst entry.
  - If it reaches TIMEOUT_CYC during a burst, abort pulses for one cycle and the FSM goes to RELEASE.
  - No rd_done/wr_done is issued for the aborted burst.
  - last_owner is still updated.
- Undefined: no counter, abort tied 0, bursts wait for mem_ack indefinitely.

Test Plan:
- Reset then rd_req=1, rd_addr=0x0100, mem_ack always 1 -> rd_gnt high one cycle later; mem_addr 0x0100..0x0107 on consecutive cycles; 8 rd_beat pulses; rd_done one cycle after the last beat.
- rd_req and wr_req both held high continuously -> grants alternate R, W, R, W. Each burst is 8 beats with one RELEASE cycle between; never both gnt high.
- Write burst wr_addr=0x2000, mem_ack pulsing every 3rd cycle -> mem_addr/mem_wdata stable between acks; wr_beat only on ack cycles; 24-cycle burst, then wr_done.
- rd_req dropped after 3 acked beats -> burst ends after beat 3; rd_done pulses; arbiter idles.
- n_rst asserted mid write burst (beat 4) -> all outputs 0 immediately. After release, the next grant goes to read on a tie.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=64, mem_ack held 0 -> abort pulses at cycle 64 of the burst; no wr_done; next burst is granted normally.
